// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: MEM->WB writes win, mul/div results queue in a FIFO and
// drain in idle cycles, with a one-cycle forced drain when the queue head starves.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_num,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  input  logic [4:0]  md_num,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        pipe_stall,
  output logic        reg_write_en,
  output logic [4:0]  reg_write_num,
  output logic [31:0] reg_write_data,
  output logic [31:0] busy_mask
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MAX_WAIT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [4:0]       fifo_num_q  [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];

  logic             head_valid;
  logic             pipe_claim;
  logic             pop;
  logic             push;
  logic [PTR_W-1:0] mask_idx;

  always_comb begin
    head_valid     = (count_q != '0);
    pipe_claim     = pipe_we && (pipe_num != 5'd0);
    md_ready       = clr_n && (count_q < FULL_C);
    pipe_stall     = clr_n && head_valid && ((age_q == AGE_MAX) || (count_q == FULL_C));
    pop            = 1'b0;
    reg_write_en   = 1'b0;
    reg_write_num  = 5'd0;
    reg_write_data = 32'd0;

    if (clr_n) begin
      if (pipe_stall) begin
        pop = 1'b1;
      end else if (pipe_claim) begin
        reg_write_en   = 1'b1;
        reg_write_num  = pipe_num;
        reg_write_data = pipe_data;
      end else if (head_valid) begin
        pop = 1'b1;
      end
    end

    if (pop) begin
      reg_write_en   = 1'b1;
      reg_write_num  = fifo_num_q[rd_ptr_q];
      reg_write_data = fifo_data_q[rd_ptr_q];
    end

    // Writes to $0 complete the handshake but never occupy a slot.
    push = md_valid && md_ready && (md_num != 5'd0);

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    if (pop || !head_valid) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + 1'b1;
    end else begin
      age_d = age_q;
    end
  end

  always_comb begin
    busy_mask = 32'd0;
    mask_idx  = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (clr_n && (CNT_W'(k) < count_q)) begin
        busy_mask[fifo_num_q[mask_idx]] = 1'b1;
      end
      mask_idx = ptr_inc(mask_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      age_q    <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      age_q    <= age_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_num_q[wr_ptr_q]  <= md_num;
      fifo_data_q[wr_ptr_q] <= md_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_wb_port_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        pipe_we;
  logic [4:0]  pipe_num;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_num;
  logic [31:0] md_data;
  logic        md_ready;
  logic        pipe_stall;
  logic        reg_write_en;
  logic [4:0]  reg_write_num;
  logic [31:0] reg_write_data;
  logic [31:0] busy_mask;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .clr_n(clr_n),
    .pipe_we(pipe_we), .pipe_num(pipe_num), .pipe_data(pipe_data),
    .md_valid(md_valid), .md_num(md_num), .md_data(md_data),
    .md_ready(md_ready), .pipe_stall(pipe_stall),
    .reg_write_en(reg_write_en), .reg_write_num(reg_write_num),
    .reg_write_data(reg_write_data), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending results as an ordered queue plus head wait time.
  logic [4:0]  mq_num[$];
  logic [31:0] mq_data[$];
  int          m_age = 0;

  logic        e_ready, e_stall, e_en, e_pop, e_push;
  logic [4:0]  e_num;
  logic [31:0] e_data, e_mask;

  task automatic model_eval();
    e_ready = 0; e_stall = 0; e_en = 0; e_num = 0; e_data = 0; e_mask = 0;
    e_pop = 0; e_push = 0;
    if (clr_n) begin
      e_ready = (mq_num.size() < DEPTH);
      e_stall = (mq_num.size() > 0) && (m_age == MAX_WAIT || mq_num.size() == DEPTH);
      if (e_stall || (!(pipe_we && pipe_num != 0) && mq_num.size() > 0)) begin
        e_pop = 1; e_en = 1; e_num = mq_num[0]; e_data = mq_data[0];
      end else if (pipe_we && pipe_num != 0) begin
        e_en = 1; e_num = pipe_num; e_data = pipe_data;
      end
      foreach (mq_num[i]) e_mask[mq_num[i]] = 1'b1;
      e_push = md_valid && e_ready && (md_num != 0);
    end
  endtask

  always @(posedge clk) begin
    model_eval();
    if (!clr_n) begin
      mq_num.delete();
      mq_data.delete();
      m_age = 0;
    end else begin
      if (e_pop || mq_num.size() == 0) m_age = 0;
      else if (m_age < MAX_WAIT) m_age++;
      if (e_pop) begin
        void'(mq_num.pop_front());
        void'(mq_data.pop_front());
      end
      if (e_push) begin
        mq_num.push_back(md_num);
        mq_data.push_back(md_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      model_eval();
      chk("model md_ready",  {31'd0, md_ready},      {31'd0, e_ready});
      chk("model pipe_stall", {31'd0, pipe_stall},   {31'd0, e_stall});
      chk("model write_en",  {31'd0, reg_write_en},  {31'd0, e_en});
      chk("model write_num", {27'd0, reg_write_num}, {27'd0, e_num});
      chk("model write_data", reg_write_data, e_data);
      chk("model busy_mask",  busy_mask, e_mask);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic cn, input logic pw, input logic [4:0] pn,
                       input logic [31:0] pd, input logic mv, input logic [4:0] mn,
                       input logic [31:0] md);
    clr_n = cn; pipe_we = pw; pipe_num = pn; pipe_data = pd;
    md_valid = mv; md_num = mn; md_data = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with md_valid asserted
    drive(0, 1, 5'd3, 32'hAAAA_0003, 1, 5'd5, 32'h5555);
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst md_ready", {31'd0, md_ready}, 32'd0);
    chk("rst en", {31'd0, reg_write_en}, 32'd0);
    chk("rst mask", busy_mask, 32'd0);
    chk("rst stall", {31'd0, pipe_stall}, 32'd0);
    step();
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("release md_ready", {31'd0, md_ready}, 32'd1);
    step();

    // Idle drain
    drive(1, 0, 5'd0, 32'd0, 1, 5'd8, 32'h1234_5678);
    @(negedge clk);
    chk("drain push-cycle en", {31'd0, reg_write_en}, 32'd0);
    step();
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("drain en", {31'd0, reg_write_en}, 32'd1);
    chk("drain num", {27'd0, reg_write_num}, 32'd8);
    chk("drain data", reg_write_data, 32'h1234_5678);
    chk("drain mask set", busy_mask, 32'h0000_0100);
    step();
    @(negedge clk);
    chk("drain mask clr", busy_mask, 32'd0);
    step();

    // Pipeline priority over queued r9
    drive(1, 1, 5'd3, 32'h0000_00A3, 1, 5'd9, 32'h0000_0099);
    @(negedge clk);
    chk("prio c0 num", {27'd0, reg_write_num}, 32'd3);
    step();
    for (int c = 1; c <= 3; c++) begin
      drive(1, 1, 5'd3, 32'h0000_00A3 + c, 0, 5'd0, 32'd0);
      @(negedge clk);
      chk("prio pipe num", {27'd0, reg_write_num}, 32'd3);
      chk("prio pipe data", reg_write_data, 32'h0000_00A3 + c);
      chk("prio mask held", busy_mask, 32'h0000_0200);
      step();
    end
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("prio r9 num", {27'd0, reg_write_num}, 32'd9);
    chk("prio r9 data", reg_write_data, 32'h0000_0099);
    chk("prio r9 stall", {31'd0, pipe_stall}, 32'd0);
    step();
    @(negedge clk);
    chk("prio mask clr", busy_mask, 32'd0);
    step();

    // Starvation: forced drain in cycle 5 only
    drive(1, 1, 5'd3, 32'h0000_0033, 1, 5'd10, 32'h0000_1010);
    step();
    for (int c = 1; c <= 6; c++) begin
      drive(1, 1, 5'd3, 32'h0000_0033, 0, 5'd0, 32'd0);
      @(negedge clk);
      if (c == 5) begin
        chk("starve stall", {31'd0, pipe_stall}, 32'd1);
        chk("starve num", {27'd0, reg_write_num}, 32'd10);
        chk("starve data", reg_write_data, 32'h0000_1010);
      end else begin
        chk("starve no stall", {31'd0, pipe_stall}, 32'd0);
        chk("starve pipe num", {27'd0, reg_write_num}, 32'd3);
      end
      step();
    end
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step();

    // Full FIFO forces a drain; order kept across push+pop
    drive(1, 1, 5'd3, 32'h0000_0033, 1, 5'd11, 32'h0000_0B11);
    @(negedge clk);
    chk("full r11 ready", {31'd0, md_ready}, 32'd1);
    step();
    drive(1, 1, 5'd3, 32'h0000_0033, 1, 5'd12, 32'h0000_0B12);
    @(negedge clk);
    chk("full r12 ready", {31'd0, md_ready}, 32'd1);
    chk("full r12 stall", {31'd0, pipe_stall}, 32'd0);
    step();
    drive(1, 1, 5'd3, 32'h0000_0033, 1, 5'd14, 32'h0000_0B14);
    @(negedge clk);
    chk("full ready", {31'd0, md_ready}, 32'd0);
    chk("full stall", {31'd0, pipe_stall}, 32'd1);
    chk("full num", {27'd0, reg_write_num}, 32'd11);
    chk("full mask", busy_mask, 32'h0000_1800);
    step();
    drive(1, 0, 5'd0, 32'd0, 1, 5'd14, 32'h0000_0B14);
    @(negedge clk);
    chk("pushpop num", {27'd0, reg_write_num}, 32'd12);
    chk("pushpop ready", {31'd0, md_ready}, 32'd1);
    step();
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("order num", {27'd0, reg_write_num}, 32'd14);
    chk("order data", reg_write_data, 32'h0000_0B14);
    step();
    @(negedge clk);
    chk("order empty en", {31'd0, reg_write_en}, 32'd0);
    step();

    // Register $0 handling
    drive(1, 0, 5'd0, 32'd0, 1, 5'd0, 32'h0000_DEAD);
    @(negedge clk);
    chk("r0 push ready", {31'd0, md_ready}, 32'd1);
    step();
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("r0 no mask", busy_mask, 32'd0);
    chk("r0 no write", {31'd0, reg_write_en}, 32'd0);
    step();
    drive(1, 0, 5'd0, 32'd0, 1, 5'd13, 32'h0000_1313);
    step();
    drive(1, 1, 5'd0, 32'h0000_FFFF, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("pipe r0 head en", {31'd0, reg_write_en}, 32'd1);
    chk("pipe r0 head num", {27'd0, reg_write_num}, 32'd13);
    chk("pipe r0 head data", reg_write_data, 32'h0000_1313);
    step();
    @(negedge clk);
    chk("pipe r0 alone en", {31'd0, reg_write_en}, 32'd0);
    step();

    // Reset mid-operation discards queued results
    drive(1, 1, 5'd3, 32'h0000_0033, 1, 5'd15, 32'h0000_0F15);
    step();
    drive(1, 1, 5'd3, 32'h0000_0033, 1, 5'd16, 32'h0000_0F16);
    step();
    drive(0, 1, 5'd3, 32'h0000_0033, 1, 5'd17, 32'h0000_0F17);
    @(negedge clk);
    chk("midrst stall", {31'd0, pipe_stall}, 32'd0);
    chk("midrst mask", busy_mask, 32'd0);
    chk("midrst en", {31'd0, reg_write_en}, 32'd0);
    chk("midrst ready", {31'd0, md_ready}, 32'd0);
    step();
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("postrst mask", busy_mask, 32'd0);
    chk("postrst en", {31'd0, reg_write_en}, 32'd0);
    chk("postrst ready", {31'd0, md_ready}, 32'd1);
    step();
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
